// File: rtl/cdma_lite_pkg.sv
// -----------------------------------------------------------------------------
// cdma_lite_pkg
// Constants shared by the CDMA-lite register slave and its control master:
// register offsets within the AXI4-Lite window and the write response codes.
// -----------------------------------------------------------------------------
package cdma_lite_pkg;

    localparam logic [9:0] CDMA_SA_OFF  = 10'h18;
    localparam logic [9:0] CDMA_DA_OFF  = 10'h20;
    localparam logic [9:0] CDMA_BTT_OFF = 10'h28;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage : cdma_lite_pkg

// File: rtl/cdma_lite_regs.sv
// -----------------------------------------------------------------------------
// cdma_lite_regs
// AXI4-Lite write-only register slave holding the CDMA transfer configuration.
// AW and W are captured independently into one-entry holds; once both are held
// and no response is pending the write commits, loads the B response and, for
// a legal non-zero BTT write while idle, emits a one-cycle start pulse and
// raises busy until the engine reports done_i.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   awaddr/awvalid/awready     AXI4-Lite write address channel
//   wdata/wvalid/wready        AXI4-Lite write data channel (no strobes)
//   bresp/bvalid/bready        AXI4-Lite write response channel
//   src_addr, dst_addr, btt    configuration registers (0x18, 0x20, 0x28)
//   start                      one-cycle transfer launch pulse
//   busy                       transfer in flight
//   done_i                     engine completion pulse
// -----------------------------------------------------------------------------
module cdma_lite_regs
    import cdma_lite_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic [31:0]       src_addr,
    output logic [31:0]       dst_addr,
    output logic [31:0]       btt,
    output logic              start,
    output logic              busy,
    input  logic              done_i
);

    // Holding registers and response state
    logic              aw_held_r;
    logic [ADDR_W-1:0] awaddr_q_r;
    logic              w_held_r;
    logic [DATA_W-1:0] wdata_q_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic              start_r;
    logic              busy_r;
    logic [31:0]       src_addr_r;
    logic [31:0]       dst_addr_r;
    logic [31:0]       btt_r;

    // Decode results for the currently held access
    logic              commit_s;
    logic [1:0]        dec_resp_s;
    logic              we_sa_s;
    logic              we_da_s;
    logic              we_btt_s;
    logic              launch_s;

    // Readies depend only on registered state, never on the valids
    assign awready  = !aw_held_r && !bvalid_r;
    assign wready   = !w_held_r  && !bvalid_r;
    assign commit_s = aw_held_r && w_held_r && !bvalid_r;

    // Address decode of the held access; priority: misalignment first
    always_comb begin
        dec_resp_s = RESP_SLVERR;
        we_sa_s    = 1'b0;
        we_da_s    = 1'b0;
        we_btt_s   = 1'b0;
        launch_s   = 1'b0;
        if (awaddr_q_r[1:0] != 2'b00) begin
            dec_resp_s = RESP_SLVERR;
        end else if (awaddr_q_r == ADDR_W'(CDMA_SA_OFF)) begin
            dec_resp_s = RESP_OKAY;
            we_sa_s    = 1'b1;
        end else if (awaddr_q_r == ADDR_W'(CDMA_DA_OFF)) begin
            dec_resp_s = RESP_OKAY;
            we_da_s    = 1'b1;
        end else if (awaddr_q_r == ADDR_W'(CDMA_BTT_OFF)) begin
            if (busy_r) begin
                // Reprogramming the length mid-transfer is refused outright
                dec_resp_s = RESP_SLVERR;
            end else begin
                dec_resp_s = RESP_OKAY;
                we_btt_s   = 1'b1;
                launch_s   = (wdata_q_r != {DATA_W{1'b0}});
            end
        end else begin
            dec_resp_s = RESP_SLVERR;
        end
    end

    // AW/W capture, commit and B channel handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_r  <= 1'b0;
            awaddr_q_r <= {ADDR_W{1'b0}};
            w_held_r   <= 1'b0;
            wdata_q_r  <= {DATA_W{1'b0}};
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else begin
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= dec_resp_s;
            end else begin
                if (awvalid && awready) begin
                    aw_held_r  <= 1'b1;
                    awaddr_q_r <= awaddr;
                end else begin
                    aw_held_r  <= aw_held_r;
                end
                if (wvalid && wready) begin
                    w_held_r  <= 1'b1;
                    wdata_q_r <= wdata;
                end else begin
                    w_held_r  <= w_held_r;
                end
                // commit requires bvalid low, so both branches never collide
                if (bvalid_r && bready) begin
                    bvalid_r <= 1'b0;
                end else begin
                    bvalid_r <= bvalid_r;
                end
            end
        end
    end

    // Configuration register updates on a legal commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_addr_r <= 32'h0000_0000;
            dst_addr_r <= 32'h0000_0000;
            btt_r      <= 32'h0000_0000;
        end else begin
            if (commit_s && we_sa_s) begin
                src_addr_r <= 32'(wdata_q_r);
            end
            if (commit_s && we_da_s) begin
                dst_addr_r <= 32'(wdata_q_r);
            end
            if (commit_s && we_btt_s) begin
                btt_r <= 32'(wdata_q_r);
            end
        end
    end

    // Start pulse and busy tracking; a launch outranks a coincident done_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            start_r <= commit_s && launch_s;
            if (commit_s && launch_s) begin
                busy_r <= 1'b1;
            end else if (done_i && busy_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign bvalid   = bvalid_r;
    assign bresp    = bresp_r;
    assign start    = start_r;
    assign busy     = busy_r;
    assign src_addr = src_addr_r;
    assign dst_addr = dst_addr_r;
    assign btt      = btt_r;

endmodule : cdma_lite_regs

// File: tb/tb_cdma_lite_regs.sv
// -----------------------------------------------------------------------------
// tb_cdma_lite_regs
// Directed bench for cdma_lite_regs with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cdma_lite_regs;

    logic        clk;
    logic        rst_n;
    logic [9:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] btt;
    logic        start;
    logic        busy;
    logic        done_i;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    cdma_lite_regs #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .btt      (btt),
        .start    (start),
        .busy     (busy),
        .done_i   (done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every start pulse seen on a rising edge
    always @(posedge clk) begin
        if (rst_n && start) start_cnt <= start_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive AW and/or W until each handshakes; returns 1ns after the last handshake edge
    task automatic do_write(input logic [9:0] a, input logic [31:0] d,
                            input bit send_aw, input bit send_w);
        bit aw_done;
        bit w_done;
        bit hs_aw;
        bit hs_w;
        int n;
        aw_done = !send_aw;
        w_done  = !send_w;
        n = 0;
        awaddr  = a;
        wdata   = d;
        awvalid = send_aw;
        wvalid  = send_w;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        if (!(aw_done && w_done)) begin
            check_val("hs_timeout", 32'd0, 32'd1);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    // Full write: commit one edge after the handshake, check response/start,
    // then complete B on the following edge when bready is high
    task automatic write_and_check(input string tag, input logic [9:0] a, input logic [31:0] d,
                                   input bit send_aw, input bit send_w,
                                   input logic [1:0] exp_resp, input logic exp_start,
                                   input bit done_at_commit);
        do_write(a, d, send_aw, send_w);
        if (done_at_commit) done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
        @(negedge clk);
        check_val({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check_val({tag, "_bresp"},  32'(bresp),  32'(exp_resp));
        check_val({tag, "_start"},  32'(start),  32'(exp_start));
        if (bready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        awaddr  = 10'h000;
        awvalid = 1'b0;
        wdata   = 32'h0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        done_i  = 1'b0;
        #12;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_val("rst_awready", 32'(awready), 32'd1);
        check_val("rst_wready",  32'(wready),  32'd1);
        check_val("rst_bvalid",  32'(bvalid),  32'd0);
        check_val("rst_busy",    32'(busy),    32'd0);
        check_val("rst_src",     src_addr,     32'h0);
        check_val("rst_btt",     btt,          32'h0);
        @(posedge clk); #1;

        // Same-cycle AW/W to SRC_ADDR
        write_and_check("sa1", 10'h018, 32'h0000_1000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check_val("sa1_src",      src_addr,     32'h0000_1000);
        check_val("sa1_awready",  32'(awready), 32'd1);
        check_val("sa1_bvalid",   32'(bvalid),  32'd0);
        @(posedge clk); #1;

        // Programming sequence ending with a launch
        write_and_check("seq_sa",  10'h018, 32'h100, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        write_and_check("seq_da",  10'h020, 32'h200, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        write_and_check("seq_btt", 10'h028, 32'h040, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        @(negedge clk);
        check_val("seq_src",   src_addr,  32'h100);
        check_val("seq_dst",   dst_addr,  32'h200);
        check_val("seq_btt_v", btt,       32'h040);
        check_val("seq_busy",  32'(busy), 32'd1);
        check_val("seq_start_gone", 32'(start), 32'd0);
        check_val("seq_start_cnt", 32'(start_cnt), 32'd1);
        @(posedge clk); #1;
        pulse_done();
        @(negedge clk);
        check_val("done_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // W three cycles ahead of AW
        wdata  = 32'h0000_ABCD;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        check_val("wfirst_wready",  32'(wready),  32'd0);
        check_val("wfirst_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("wfirst_nobvalid", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        write_and_check("wfirst", 10'h020, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check_val("wfirst_dst", dst_addr, 32'h0000_ABCD);
        @(posedge clk); #1;

        // Launch, then a BTT write while busy is refused
        write_and_check("btt_go",   10'h028, 32'h20, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        write_and_check("btt_busy", 10'h028, 32'h10, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        write_and_check("bad_1c",   10'h01C, 32'hDEAD, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        write_and_check("bad_19",   10'h019, 32'hBEEF, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        @(negedge clk);
        check_val("busy_btt_kept", btt,       32'h20);
        check_val("bad_src_kept",  src_addr,  32'h100);
        check_val("bad_dst_kept",  dst_addr,  32'h0000_ABCD);
        check_val("busy_still",    32'(busy), 32'd1);
        @(posedge clk); #1;

        // Back-pressure on B
        bready = 1'b0;
        write_and_check("bp", 10'h018, 32'h55, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        awaddr  = 10'h020;
        wdata   = 32'h77;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("bp_bvalid",  32'(bvalid),  32'd1);
            check_val("bp_bresp",   32'(bresp),   32'd0);
            check_val("bp_awready", 32'(awready), 32'd0);
            check_val("bp_wready",  32'(wready),  32'd0);
        end
        check_val("bp_dst_held", dst_addr, 32'h0000_ABCD);
        bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rel_bvalid",  32'(bvalid),  32'd0);
        check_val("rel_awready", 32'(awready), 32'd1);
        check_val("rel_wready",  32'(wready),  32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rel_commit", 32'(bvalid), 32'd1);
        check_val("rel_dst",    dst_addr,    32'h77);
        check_val("bp_src",     src_addr,    32'h55);
        @(posedge clk); #1;

        // Clear busy, then launch on the same edge as a done_i pulse
        pulse_done();
        @(negedge clk);
        check_val("done2_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        write_and_check("race", 10'h028, 32'h8, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        check_val("race_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        pulse_done();
        pulse_done();
        @(negedge clk);
        check_val("idle_done_busy", 32'(busy), 32'd0);
        check_val("start_total", 32'(start_cnt), 32'd3);
        @(posedge clk); #1;

        // Reset with AW held and no W
        awaddr  = 10'h018;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check_val("pre_rst_awready", 32'(awready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("mrst_bvalid",  32'(bvalid),  32'd0);
        check_val("mrst_awready", 32'(awready), 32'd1);
        check_val("mrst_wready",  32'(wready),  32'd1);
        check_val("mrst_src",     src_addr,     32'h0);
        check_val("mrst_dst",     dst_addr,     32'h0);
        check_val("mrst_btt",     btt,          32'h0);
        check_val("mrst_busy",    32'(busy),    32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("mrst_no_b", 32'(bvalid), 32'd0);
        end
        @(posedge clk); #1;
        write_and_check("btt0", 10'h028, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check_val("btt0_val",  btt,       32'h0);
        check_val("btt0_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cdma_lite_regs

// File: doc/cdma_lite_regs.md
# cdma_lite_regs

AXI4-Lite write-channel responder holding the CDMA transfer configuration: source address, destination address and byte length. It is the slave end of the control path driven by the CDMA control master, and it turns a write of the byte-length register into a one-cycle `start` pulse for the datapath engine. It tracks `busy` until the engine reports `done_i`.

## Interface
Parameters:
- `ADDR_W`, 10: AW address width.
- `DATA_W`, 32: W data width.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `awaddr`  in  ADDR_W  write address.
- `awvalid`  in  1  AW valid.
- `awready`  out  1  AW ready.
- `wdata`  in  DATA_W  write data.
- `wvalid`  in  1  W valid.
- `wready`  out  1  W ready.
- `bresp`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- `bvalid`  out  1  B valid.
- `bready`  in  1  B ready.
- `src_addr`  out  32  SRC_ADDR register, offset 0x18.
- `dst_addr`  out  32  DST_ADDR register, offset 0x20.
- `btt`  out  32  BTT (bytes to transfer) register, offset 0x28.
- `start`  out  1  one-cycle pulse that launches a transfer.
- `busy`  out  1  transfer in flight.
- `done_i`  in  1  engine completion pulse.

## Operation
- **Independent capture.** AW and W channels are accepted independently into one-entry holding registers `aw_held`/`awaddr_q` and `w_held`/`wdata_q`.
  - `awready = !aw_held & !bvalid`
  - `wready = !w_held & !bvalid`
  - Either order and same-cycle arrival are all legal.
- **Commit.** The write commits on the first edge where both holds are full and `bvalid=0`. At that edge:
  - both holds clear;
  - `bvalid` is set;
  - `bresp` is loaded;
  - the register is updated if the access is legal.
- **Decode.** Checked in this order on `awaddr_q`:
  - `awaddr_q[1:0]!=0` → SLVERR, no update.
  - 0x18 → `src_addr <= wdata_q`, OKAY.
  - 0x20 → `dst_addr <= wdata_q`, OKAY.
  - 0x28 while `busy=1` → SLVERR, no update, no start.
  - 0x28 while `busy=0` → `btt <= wdata_q`, OKAY. If `wdata_q!=0`, also `start=1` for that one cycle and `busy <= 1`. If `wdata_q==0`, the value is stored and no start is issued.
  - Any other offset → SLVERR, no update.
- **B channel.** `bvalid` holds with a stable `bresp` until `bvalid & bready`, then clears on that edge. No new AW or W is accepted while `bvalid=1`.
- **Busy tracking.** `busy` clears on the edge where `done_i=1` and `busy=1`. `done_i` while `busy=0` is ignored. If a start commit and `done_i` fall on the same edge, the start wins and `busy` stays 1.
- **Reset.**
  - Holds, `bvalid`, `start`, `busy` = 0; `bresp` = 2'b00.
  - `src_addr`, `dst_addr`, `btt` = 0.
  - `awready` and `wready` are 1 as soon as `rst_n` deasserts.
  - Reset mid-transaction discards held AW/W and any pending B, with no response issued.

## Timing
- AW+W handshake at edge N → commit at edge N+1: register visible and `bvalid=1` in cycle N+1, `start` high for exactly cycle N+1.
- AW at edge N, W at edge M>N → commit at edge M+1.
- With `bready` tied high, B handshake at edge N+2 and readies return in cycle N+2. Sustained throughput is one write per 3 cycles.
- `awready`/`wready` are combinational from registered state only; there is no valid→ready combinational path.
- `start` is registered, with no combinational path from the AXI inputs.

## Structure
- Shared package `cdma_lite_pkg`:
  - offsets `CDMA_SA_OFF=10'h18`, `CDMA_DA_OFF=10'h20`, `CDMA_BTT_OFF=10'h28`;
  - response codes `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
  - The control master uses the same constants.
- No sub-module. The two holding registers are small enough to stay inline.

## Test plan
- Reset, then AW=0x18/W=0x1000 in the same cycle → `src_addr=0x1000` in the next cycle, `bvalid=1`, `bresp=00`, `start=0`.
- Sequence 0x18/0x100, 0x20/0x200, 0x28/0x40 with `bready=1` → three OKAY responses, `start` pulses once with `btt=0x40`, then `busy=1`. `done_i` pulse → `busy=0`.
- W=0xABCD three cycles before AW=0x20 → `wready` low after W is captured, commit one cycle after AW, `dst_addr=0xABCD`.
- Write 0x28/0x10 while `busy=1` → `bresp=10`, `btt` unchanged, no `start`. Write to 0x1C or 0x19 → SLVERR, no register change.
- Hold `bready=0` for 5 cycles after a commit → `bvalid` and `bresp` stable, `awready=wready=0`, a new AW/W is held off. Release → acceptance resumes the next cycle.
- Assert `rst_n=0` with AW held and W not yet sent → after release, no `bvalid`, all registers 0, readies 1. BTT=0 write → OKAY, no `start`.
